dl_fec_encoder: RTL and testbench
=================================

Name: dl_fec_encoder

Overview:
- Downlink-side FEC encoder. Produces the CRC and 2D-parity fields that the uplink FEC decode cluster checks.
- Accepts a payload in one of two cluster formats, selected by `enc_sel`:
  - 0: 56-bit data + CRC-8, arranged as an 8x8 matrix.
  - 1: 12-bit data + CRC-4, arranged as a 4x4 matrix.
- Computes the CRC sequentially, then computes row/column parity over {crc, data}.
- Presents the codeword on a valid/ready output handshake toward the downlink framer.

Parameters:
- CRC0_WIDTH, 8, CRC width for the 64-bit cluster
- CRC0_POLY, 8'h07, CRC-8 polynomial (x^8 implicit)
- CRC1_WIDTH, 4, CRC width for the 16-bit cluster
- CRC1_POLY, 4'h3, CRC-4 polynomial (x^4 implicit)
- BITS_PER_CYCLE, 4, payload bits folded into the CRC per clock; must divide 56 and 12

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- enc_sel  in  1  0 = 64-bit cluster, 1 = 16-bit cluster
- data_in  in  56  payload; mode 1 uses data_in[11:0], upper bits ignored
- busy  out  1  high from start acceptance until output handshake completes
- out_valid  out  1  codeword/parity valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- enc_sel_o  out  1  captured enc_sel for the current codeword
- crc_out  out  8  CRC; mode 1 in [3:0], [7:4]=0
- cw_out  out  64  mode 0: {crc8, data[55:0]}; mode 1: {48'b0, crc4, data[11:0]}
- row_p  out  8  row parity; mode 1 in [3:0], upper 0
- col_p  out  8  column parity; mode 1 in [3:0], upper 0

Behaviour:
- Reset (rst_n low at posedge): FSM=IDLE. busy, out_valid, enc_sel_o, crc_out, cw_out, row_p, col_p all 0. Reset mid-operation aborts the job; no output is produced.
- States and transitions:
  - IDLE: on start=1, capture enc_sel and data_in (mode 1 zero-extends [11:0]), clear the CRC register, go to CRC; busy=1 from the next cycle.
  - CRC: each cycle fold BITS_PER_CYCLE bits, MSB first (data[55] first in mode 0, data[11] first in mode 1). Steps: 14 in mode 0, 3 in mode 1.
  - PARITY: single cycle; registers crc_out, cw_out, row_p, col_p; out_valid rises with them.
  - DONE: hold all outputs stable while out_valid=1 and out_ready=0. On out_valid&out_ready go to IDLE, out_valid=0, busy=0; data outputs keep their last values.
- CRC rule, per bit b:
  - fb = crc[W-1]^b
  - crc = {crc[W-2:0],1'b0} ^ (fb ? POLY : 0)
  - init 0, no reflection, no final XOR.
- Matrix: codeword bits arranged as rows of N bits (N=8 or 4); row i = cw[N*i+N-1 : N*i].
  - row_p[i] = ^row i.
  - col_p[j] = XOR over i of cw[N*i+j].
  - Even parity throughout.
- Latency: start sampled at edge T → out_valid visible after edge T+15 (mode 0) or T+4 (mode 1). out_ready=1 in the first valid cycle gives a one-cycle out_valid pulse.
- start while busy: ignored; does not restart or corrupt the job.
- start in the same cycle as the output handshake: ignored (FSM not in IDLE); must be re-issued.
- enc_sel/data_in changes after acceptance: no effect.

Test Plan:
- Mode 0, data_in=0, out_ready=1 → out_valid at T+15; crc_out=00, cw_out=0, row_p=00, col_p=00.
- Mode 0, data_in=56'h1 → crc_out=8'h07, cw_out=64'h0700_0000_0000_0001, row_p=8'h81, col_p=8'h06.
- Mode 1, data_in=56'hFFFF_FFFF_FFF001 → upper bits ignored; at T+4: crc_out=8'h03, cw_out=64'h3001, row_p=8'h01, col_p=8'h02, enc_sel_o=1.
- Backpressure: mode 0 data 56'h1, out_ready=0 for 10 cycles → out_valid and all outputs stable 10 cycles; busy=1; handshake on first ready → IDLE the next cycle.
- start pulses during CRC, and in the handshake cycle, with different data → ignored; first job's outputs unchanged; a fresh start afterwards processes the new data correctly.
- rst_n low for 1 cycle at step 7 of a mode-0 job → all outputs 0, no out_valid; a following start with data 56'h1 yields crc_out=8'h07.

Source files
------------

// File: rtl/dl_fec_encoder.sv
// dl_fec_encoder: downlink FEC encoder. Folds the payload into a CRC a few bits per
// clock, then forms even row/column parity over the {crc, data} matrix and offers the
// codeword on a valid/ready handshake. Two cluster formats:
//   enc_sel=0: 56-bit data + CRC-8, 8x8 matrix
//   enc_sel=1: 12-bit data + CRC-4, 4x4 matrix
module dl_fec_encoder #(
    parameter int unsigned           CRC0_WIDTH     = 8,
    parameter logic [CRC0_WIDTH-1:0] CRC0_POLY      = 8'h07,
    parameter int unsigned           CRC1_WIDTH     = 4,
    parameter logic [CRC1_WIDTH-1:0] CRC1_POLY      = 4'h3,
    parameter int unsigned           BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        enc_sel,
    input  logic [55:0] data_in,
    output logic        busy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        enc_sel_o,
    output logic [7:0]  crc_out,
    output logic [63:0] cw_out,
    output logic [7:0]  row_p,
    output logic [7:0]  col_p
);

    localparam int unsigned DATA0_W = 56;
    localparam int unsigned DATA1_W = 12;
    localparam int unsigned STEPS0  = DATA0_W / BITS_PER_CYCLE;
    localparam int unsigned STEPS1  = DATA1_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W   = $clog2(STEPS0 + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCrc,
        StParity,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Job context captured at start acceptance
    logic               sel_q;
    logic [DATA0_W-1:0] data_q;
    // Shift copy of the payload, MSB-aligned so the next bits to fold are always on top
    logic [DATA0_W-1:0] sh_q;
    logic [7:0]         crc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               last_step;
    logic               accept;

    logic [CRC0_WIDTH-1:0] c0;
    logic [CRC1_WIDTH-1:0] c1;
    logic                  fb0;
    logic                  fb1;
    logic                  bit_in;
    logic [7:0]            crc_next;

    logic [63:0] cw0;
    logic [15:0] cw1;
    logic [7:0]  row0;
    logic [7:0]  col0;
    logic [3:0]  row1;
    logic [3:0]  col1;
    logic [63:0] cw_d;
    logic [7:0]  crc_d;
    logic [7:0]  row_d;
    logic [7:0]  col_d;

    assign accept    = (state_q == StIdle) && start;
    assign last_step = sel_q ? (cnt_q == CNT_W'(STEPS1 - 1)) : (cnt_q == CNT_W'(STEPS0 - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; start outside IDLE is deliberately ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start)     state_d = StCrc;
            StCrc:    if (last_step) state_d = StParity;
            StParity:                state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:                 state_d = StIdle;
        endcase
    end

    // FSM outputs: busy spans acceptance through handshake, valid only while holding result
    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
    end

    // Job capture and per-cycle CRC folding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            data_q <= '0;
            sh_q   <= '0;
            crc_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            sel_q <= enc_sel;
            if (enc_sel) begin
                data_q <= {{(DATA0_W - DATA1_W){1'b0}}, data_in[DATA1_W-1:0]};
                sh_q   <= {data_in[DATA1_W-1:0], {(DATA0_W - DATA1_W){1'b0}}};
            end else begin
                data_q <= data_in;
                sh_q   <= data_in;
            end
            crc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == StCrc) begin
            crc_q <= crc_next;
            sh_q  <= sh_q << BITS_PER_CYCLE;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fold BITS_PER_CYCLE bits MSB-first through both CRC widths; sel picks the result
    always_comb begin
        c0       = crc_q[CRC0_WIDTH-1:0];
        c1       = crc_q[CRC1_WIDTH-1:0];
        fb0      = 1'b0;
        fb1      = 1'b0;
        bit_in   = 1'b0;
        crc_next = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            bit_in = sh_q[DATA0_W-1-i];
            fb0    = c0[CRC0_WIDTH-1] ^ bit_in;
            c0     = {c0[CRC0_WIDTH-2:0], 1'b0} ^ (fb0 ? CRC0_POLY : '0);
            fb1    = c1[CRC1_WIDTH-1] ^ bit_in;
            c1     = {c1[CRC1_WIDTH-2:0], 1'b0} ^ (fb1 ? CRC1_POLY : '0);
        end
        if (sel_q) begin
            crc_next[CRC1_WIDTH-1:0] = c1;
        end else begin
            crc_next[CRC0_WIDTH-1:0] = c0;
        end
    end

    // Codeword assembly and row/column parity for both matrix sizes
    always_comb begin
        cw0  = {crc_q[CRC0_WIDTH-1:0], data_q};
        cw1  = {crc_q[CRC1_WIDTH-1:0], data_q[DATA1_W-1:0]};
        row0 = '0;
        col0 = '0;
        row1 = '0;
        col1 = '0;
        for (int i = 0; i < 8; i++) begin
            row0[i] = ^cw0[8*i +: 8];
            for (int j = 0; j < 8; j++) begin
                col0[j] = col0[j] ^ cw0[8*i+j];
            end
        end
        for (int i = 0; i < 4; i++) begin
            row1[i] = ^cw1[4*i +: 4];
            for (int j = 0; j < 4; j++) begin
                col1[j] = col1[j] ^ cw1[4*i+j];
            end
        end
        if (sel_q) begin
            cw_d  = {48'b0, cw1};
            crc_d = {4'b0, crc_q[CRC1_WIDTH-1:0]};
            row_d = {4'b0, row1};
            col_d = {4'b0, col1};
        end else begin
            cw_d  = cw0;
            crc_d = crc_q;
            row_d = row0;
            col_d = col0;
        end
    end

    // Result registers: loaded once in PARITY, held through DONE and after the handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_sel_o <= 1'b0;
            crc_out   <= '0;
            cw_out    <= '0;
            row_p     <= '0;
            col_p     <= '0;
        end else if (state_q == StParity) begin
            enc_sel_o <= sel_q;
            crc_out   <= crc_d;
            cw_out    <= cw_d;
            row_p     <= row_d;
            col_p     <= col_d;
        end
    end

endmodule

// File: tb/tb_dl_fec_encoder.sv
// tb_dl_fec_encoder: directed and randomized checks of dl_fec_encoder against a
// bit-serial CRC and matrix-parity reference model.
module tb_dl_fec_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        enc_sel;
    logic [55:0] data_in;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic        enc_sel_o;
    logic [7:0]  crc_out;
    logic [63:0] cw_out;
    logic [7:0]  row_p;
    logic [7:0]  col_p;

    int errors = 0;
    int checks = 0;

    dl_fec_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .enc_sel   (enc_sel),
        .data_in   (data_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .enc_sel_o (enc_sel_o),
        .crc_out   (crc_out),
        .cw_out    (cw_out),
        .row_p     (row_p),
        .col_p     (col_p)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until out_valid, bounded so a stuck DUT still reaches the summary
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Reference CRC: one bit at a time over the payload, MSB first
    function automatic logic [7:0] ref_crc(bit mode, logic [55:0] d);
        int w, n, poly, crc, fb;
        w    = mode ? 4 : 8;
        n    = mode ? 12 : 56;
        poly = mode ? 3 : 7;
        crc  = 0;
        for (int k = n - 1; k >= 0; k--) begin
            fb  = ((crc >> (w - 1)) & 1) ^ int'(d[k]);
            crc = (crc << 1) & ((1 << w) - 1);
            if (fb != 0) crc = crc ^ poly;
        end
        return 8'(crc);
    endfunction

    function automatic logic [63:0] ref_cw(bit mode, logic [55:0] d, logic [7:0] crc);
        if (mode) return {48'b0, crc[3:0], d[11:0]};
        return {crc, d};
    endfunction

    // Reference parity: lay the codeword out as an n x n bit matrix; returns {row, col}
    function automatic logic [15:0] ref_parity(bit mode, logic [63:0] cw);
        int n;
        bit m [8][8];
        logic [7:0] r, c;
        n = mode ? 4 : 8;
        r = '0;
        c = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                m[i][j] = cw[n*i+j];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                r[i] = r[i] ^ m[i][j];
                c[j] = c[j] ^ m[i][j];
            end
        return {r, c};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        enc_sel   = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (enc_sel_o !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b expected 0", enc_sel_o); end
        checks++; if (crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc: got %h expected 00", crc_out); end
        checks++; if (cw_out !== 64'h0) begin errors++; $display("FAIL reset_cw: got %h expected 0", cw_out); end
        checks++; if ({row_p, col_p} !== 16'h0) begin errors++; $display("FAIL reset_par: got %h expected 0000", {row_p, col_p}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_directed();
        bit          modes [3] = '{1'b0, 1'b0, 1'b1};
        logic [55:0] din   [3] = '{56'h0, 56'h1, 56'hFF_FFFF_FFFF_F001};
        logic [7:0]  e_crc [3] = '{8'h00, 8'h07, 8'h03};
        logic [63:0] e_cw  [3] = '{64'h0, 64'h0700_0000_0000_0001, 64'h3001};
        logic [7:0]  e_row [3] = '{8'h00, 8'h81, 8'h01};
        logic [7:0]  e_col [3] = '{8'h00, 8'h06, 8'h02};
        int          e_lat [3] = '{15, 15, 4};
        int lat;
        for (int v = 0; v < 3; v++) begin
            out_ready = 1'b1;
            enc_sel   = modes[v];
            data_in   = din[v];
            start     = 1'b1;
            step();
            start   = 1'b0;
            enc_sel = ~modes[v];
            data_in = 56'({$urandom(), $urandom()});
            wait_valid(lat);
            checks++; if (lat !== e_lat[v]) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", v, lat, e_lat[v]); end
            checks++; if (crc_out !== e_crc[v]) begin errors++; $display("FAIL dir%0d_crc: got %h expected %h", v, crc_out, e_crc[v]); end
            checks++; if (cw_out !== e_cw[v]) begin errors++; $display("FAIL dir%0d_cw: got %h expected %h", v, cw_out, e_cw[v]); end
            checks++; if (row_p !== e_row[v]) begin errors++; $display("FAIL dir%0d_row: got %h expected %h", v, row_p, e_row[v]); end
            checks++; if (col_p !== e_col[v]) begin errors++; $display("FAIL dir%0d_col: got %h expected %h", v, col_p, e_col[v]); end
            checks++; if (enc_sel_o !== modes[v]) begin errors++; $display("FAIL dir%0d_sel: got %b expected %b", v, enc_sel_o, modes[v]); end
            step();
            checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL dir%0d_pulse: got valid,busy=%b expected 00", v, {out_valid, busy}); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit          mode;
        logic [55:0] d;
        logic [7:0]  e_crc;
        logic [63:0] e_cw;
        logic [15:0] e_par;
        logic [89:0] exp_pk, obs_pk;
        int lat, delay;
        for (int n = 0; n < 24; n++) begin
            mode    = 1'($urandom_range(0, 1));
            d       = 56'({$urandom(), $urandom()});
            delay   = $urandom_range(0, 3);
            e_crc   = ref_crc(mode, d);
            e_cw    = ref_cw(mode, d, e_crc);
            e_par   = ref_parity(mode, e_cw);
            exp_pk  = {1'b1, mode, e_crc, e_cw, e_par};
            out_ready = 1'b0;
            enc_sel   = mode;
            data_in   = d;
            start     = 1'b1;
            step();
            start   = 1'b0;
            data_in = 56'({$urandom(), $urandom()});
            enc_sel = 1'($urandom_range(0, 1));
            wait_valid(lat);
            checks++; if (lat !== (mode ? 4 : 15)) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, mode ? 4 : 15); end
            for (int k = 0; k <= delay; k++) begin
                if (k == delay) out_ready = 1'b1;
                obs_pk = {out_valid, enc_sel_o, crc_out, cw_out, row_p, col_p};
                checks++; if (obs_pk !== exp_pk) begin errors++; $display("FAIL rnd%0d_out: got %h expected %h", n, obs_pk, exp_pk); end
                step();
            end
            checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL rnd%0d_release: got valid,busy=%b expected 00", n, {out_valid, busy}); end
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic [89:0] exp_pk, obs_pk;
        int lat;
        exp_pk    = {1'b1, 1'b1, 1'b0, 8'h07, 64'h0700_0000_0000_0001, 8'h81, 8'h06};
        out_ready = 1'b0;
        enc_sel   = 1'b0;
        data_in   = 56'h1;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL bp_latency: got %0d expected 15", lat); end
        for (int k = 0; k < 10; k++) begin
            obs_pk = {out_valid, busy, enc_sel_o, crc_out, cw_out, row_p, col_p};
            checks++; if (obs_pk !== exp_pk) begin errors++; $display("FAIL bp_hold%0d: got %h expected %h", k, obs_pk, exp_pk); end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got valid,busy=%b expected 00", {out_valid, busy}); end
        checks++; if (cw_out !== 64'h0700_0000_0000_0001) begin errors++; $display("FAIL bp_keep_cw: got %h expected 0700000000000001", cw_out); end
    endtask

    task automatic test_start_ignored();
        logic [55:0] da, db;
        logic [7:0]  ca, cb;
        logic [63:0] wa, wb;
        logic [89:0] exp_a, exp_b, obs_pk;
        int lat;
        da    = 56'({$urandom(), $urandom()});
        db    = 56'({$urandom(), $urandom()});
        db[0] = ~da[0];
        ca    = ref_crc(1'b0, da);
        wa    = ref_cw(1'b0, da, ca);
        exp_a = {1'b1, 1'b0, ca, wa, ref_parity(1'b0, wa)};
        cb    = ref_crc(1'b1, db);
        wb    = ref_cw(1'b1, db, cb);
        exp_b = {1'b1, 1'b1, cb, wb, ref_parity(1'b1, wb)};

        out_ready = 1'b0;
        enc_sel   = 1'b0;
        data_in   = da;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        // Stray start mid-CRC with different mode and data
        start   = 1'b1;
        enc_sel = 1'b1;
        data_in = db;
        step();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat + 6 !== 15) begin errors++; $display("FAIL ign_latency: got %0d expected 15", lat + 6); end
        obs_pk = {out_valid, enc_sel_o, crc_out, cw_out, row_p, col_p};
        checks++; if (obs_pk !== exp_a) begin errors++; $display("FAIL ign_job_a: got %h expected %h", obs_pk, exp_a); end

        // Start coincident with the handshake must not launch a job
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL ign_hs_release: got valid,busy=%b expected 00", {out_valid, busy}); end
        checks++; if (cw_out !== wa) begin errors++; $display("FAIL ign_hs_keep: got %h expected %h", cw_out, wa); end
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got busy=%b expected 0", busy); end

        out_ready = 1'b1;
        enc_sel   = 1'b1;
        data_in   = db;
        start     = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ign_b_latency: got %0d expected 4", lat); end
        obs_pk = {out_valid, enc_sel_o, crc_out, cw_out, row_p, col_p};
        checks++; if (obs_pk !== exp_b) begin errors++; $display("FAIL ign_job_b: got %h expected %h", obs_pk, exp_b); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        logic [78:0] obs_z;
        int lat, nv;
        out_ready = 1'b1;
        enc_sel   = 1'b0;
        data_in   = 56'({$urandom(), $urandom()}) | 56'h1;
        start     = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        obs_z = {busy, out_valid, enc_sel_o, crc_out, cw_out};
        checks++; if (obs_z !== '0) begin errors++; $display("FAIL mid_reset_outs: got %h expected 0", obs_z); end
        checks++; if ({row_p, col_p} !== 16'h0) begin errors++; $display("FAIL mid_reset_par: got %h expected 0000", {row_p, col_p}); end
        nv = 0;
        repeat (20) begin
            step();
            if (out_valid) nv++;
        end
        checks++; if (nv !== 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_abort: got valid cycles=%0d busy=%b expected 0 0", nv, busy); end

        data_in = 56'h1;
        start   = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        checks++; if (lat !== 15) begin errors++; $display("FAIL mid_after_latency: got %0d expected 15", lat); end
        checks++; if (crc_out !== 8'h07) begin errors++; $display("FAIL mid_after_crc: got %h expected 07", crc_out); end
        checks++; if (cw_out !== 64'h0700_0000_0000_0001) begin errors++; $display("FAIL mid_after_cw: got %h expected 0700000000000001", cw_out); end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
